scratch_pad_loader: RTL

SCRATCH_PAD_LOADER -- requirements
Module: scratch_pad_loader

---
 rtl/scratch_pad_loader.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/scratch_pad_loader.sv
// Boot-time scratchpad loader: parses an [addr][len][payload] byte stream from a UART
// receiver and turns it into word-aligned, per-lane-enabled scratchpad writes.
module scratch_pad_loader #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  input  logic [7:0]  io_in_bits,
  output logic        io_in_ready,
  output logic [31:0] io_wrAddress,
  output logic [31:0] io_wrData,
  output logic        io_wrEnable_0,
  output logic        io_wrEnable_1,
  output logic        io_wrEnable_2,
  output logic        io_wrEnable_3,
  output logic        io_busy,
  output logic        io_done,
  output logic        io_error
);

  typedef enum logic [2:0] {
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [32:0] MEM_SPAN = 33'(MEM_BYTES);

  // NOTE: reset asserts asynchronously but releases through two flops, so every state
  // flop leaves reset on the same clean edge regardless of when the pin rises.
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n      = rst_sync_q[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  state_e      state_q,   state_d;
  logic [1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [31:0] addr_q,    addr_d;
  logic [31:0] len_q,     len_d;
  logic [31:0] cur_q,     cur_d;
  logic [31:0] rem_q,     rem_d;
  logic [31:0] data_q,    data_d;
  logic [3:0]  mask_q,    mask_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [3:0]  wr_en_q,   wr_en_d;

  logic        ready_state;
  logic        accept;
  logic [1:0]  lane;
  logic [3:0]  lane_bit;
  logic [31:0] byte_word;
  logic [31:0] len_full;
  logic [32:0] span_end;
  logic        last_byte;

  assign ready_state = (state_q == ST_ADDR) || (state_q == ST_LEN) || (state_q == ST_DATA);
  // Ready reads 1 while reset is held, but stays low during the release window.
  assign io_in_ready = ready_state && (rst_n || !reset);
  assign accept      = io_in_valid && io_in_ready;

  assign lane      = cur_q[1:0];
  assign lane_bit  = 4'b0001 << lane;
  assign byte_word = {24'd0, io_in_bits} << {lane, 3'b000};
  assign len_full  = {io_in_bits, len_q[31:8]};
  assign span_end  = {1'b0, addr_q} + {1'b0, len_full};
  assign last_byte = (rem_q == 32'd1);

  // NOTE: every variable gets its default first, so no path through the case can infer a latch.
  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cur_d     = cur_q;
    rem_d     = rem_q;
    data_d    = data_q;
    mask_d    = mask_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = 32'd0;
    wr_en_d   = 4'd0;

    case (state_q)
      ST_ADDR: begin
        if (accept) begin
          addr_d    = {io_in_bits, addr_q[31:8]};
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            state_d = ST_LEN;
          end
        end
      end

      ST_LEN: begin
        if (accept) begin
          len_d     = len_full;
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            if (len_full == 32'd0) begin
              state_d = ST_DONE;
            end else if (span_end > MEM_SPAN) begin
              state_d = ST_ERR;
            end else begin
              state_d = ST_DATA;
              cur_d   = addr_q;
              rem_d   = len_full;
            end
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          cur_d = cur_q + 32'd1;
          rem_d = rem_q - 32'd1;
          // A word is emitted once its top lane fills or the payload runs out.
          if ((lane == 2'd3) || last_byte) begin
            wr_addr_d = {cur_q[31:2], 2'b00};
            wr_data_d = data_q | byte_word;
            wr_en_d   = mask_q | lane_bit;
            data_d    = 32'd0;
            mask_d    = 4'd0;
          end else begin
            data_d = data_q | byte_word;
            mask_d = mask_q | lane_bit;
          end
          if (last_byte) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d   = ST_ADDR;
        hdr_cnt_d = 2'd0;
      end

      ST_ERR: begin
        state_d = ST_ERR;
      end

      default: begin
        state_d = ST_ADDR;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ADDR;
      hdr_cnt_q <= 2'd0;
      addr_q    <= 32'd0;
      len_q     <= 32'd0;
      cur_q     <= 32'd0;
      rem_q     <= 32'd0;
      data_q    <= 32'd0;
      mask_q    <= 4'd0;
      wr_addr_q <= 32'd0;
      wr_data_q <= 32'd0;
      wr_en_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cur_q     <= cur_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
    end
  end

  assign io_wrAddress  = wr_addr_q;
  assign io_wrData     = wr_data_q;
  assign io_wrEnable_0 = wr_en_q[0];
  assign io_wrEnable_1 = wr_en_q[1];
  assign io_wrEnable_2 = wr_en_q[2];
  assign io_wrEnable_3 = wr_en_q[3];

  // Busy covers the whole frame from the first header byte through the DONE cycle.
  assign io_busy  = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_DONE) ||
                    ((state_q == ST_ADDR) && (hdr_cnt_q != 2'd0));
  assign io_done  = (state_q == ST_DONE);
  assign io_error = (state_q == ST_ERR);

endmodule
